endstop_event_arbiter: RTL and testbench

Sequencer that services a bank of debounced endstop/probe channels. It collects latched edge events from up to N_CH debounce channels and arbitrates between them round-robin. It presents one event at a time, with captured position and change count, to the host register interface over a valid/ready port. After the host accepts an event, it pulses that channel's unlock so the channel re-arms.

---
 rtl/endstop_event_arbiter_pkg.sv | 21 ++
 rtl/endstop_event_arbiter_if.sv | 38 +++
 rtl/endstop_event_arbiter_rr_arbiter.sv | 45 ++++
 rtl/endstop_event_arbiter.sv | 124 ++++++++++++
 tb/tb_endstop_event_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/endstop_event_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : endstop_pkg
// Description : Shared FSM state encoding and width constants for the endstop
//               event arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package endstop_pkg;
    localparam int CYC_W = 8;
    localparam int TS_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        UNLOCK  = 2'd2,
        SETTLE  = 2'd3
    } state_t;
endpackage

`default_nettype wire

// File: rtl/endstop_event_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : endstop_event_arbiter_if
// Description : Event valid/ready port between the arbiter and the host
//               register block. evt_time exists only with ENDSTOP_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface endstop_event_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int POS_W = 64
);
    import endstop_pkg::*;

    logic                     evt_valid;
    logic                     evt_ready;
    logic [$clog2(N_CH)-1:0]  evt_ch;
    logic                     evt_value;
    logic [POS_W-1:0]         evt_pos;
    logic [CYC_W-1:0]         evt_missed;
`ifdef ENDSTOP_TIMESTAMP_EN
    logic [TS_W-1:0]          evt_time;

    modport master (output evt_valid, input evt_ready, output evt_ch,
                    output evt_value, output evt_pos, output evt_missed,
                    output evt_time);
    modport slave  (input evt_valid, output evt_ready, input evt_ch,
                    input evt_value, input evt_pos, input evt_missed,
                    input evt_time);
`else
    modport master (output evt_valid, input evt_ready, output evt_ch,
                    output evt_value, output evt_pos, output evt_missed);
    modport slave  (input evt_valid, output evt_ready, input evt_ch,
                    input evt_value, input evt_pos, input evt_missed);
`endif
endinterface

`default_nettype wire

// File: rtl/endstop_event_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or after
//               i_ptr, wrapping modulo N_CH. One-hot grant plus index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  wire logic [N_CH-1:0] i_req,
    input  wire logic [CH_W-1:0] i_ptr,
    output logic      [N_CH-1:0] o_grant,
    output logic      [CH_W-1:0] o_grant_idx,
    output logic                 o_grant_vld
);
    int              w_sum;
    logic [CH_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_sum       = 0;
        w_idx       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_sum = int'(i_ptr) + i;
            if (w_sum >= N_CH) begin
                w_sum = w_sum - N_CH;
            end
            w_idx = w_sum[CH_W-1:0];
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_grant_vld    = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/endstop_event_arbiter.sv
//------------------------------------------------------------------------------
// Module      : endstop_event_arbiter
// Description : Round-robin sequencer presenting latched endstop events to the
//               host and re-arming the channel after acceptance.
//               Optional capture timestamp: define ENDSTOP_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module endstop_event_arbiter
    import endstop_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int POS_W = 64
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic [N_CH-1:0]         ch_enable,
    input  wire logic [N_CH-1:0]         ch_changed,
    input  wire logic [N_CH-1:0]         ch_value,
    input  wire logic [N_CH*POS_W-1:0]   ch_pos,
    input  wire logic [N_CH*CYC_W-1:0]   ch_cycles,
    output logic      [N_CH-1:0]         ch_unlock,
    endstop_event_arbiter_if.master      evt
);
    localparam int CH_W = $clog2(N_CH);

    state_t           r_state;
    logic [CH_W-1:0]  r_rr_ptr;
    logic [N_CH-1:0]  r_grant_oh;
    logic [CYC_W-1:0] r_last_cyc [N_CH];

    logic [N_CH-1:0]  w_pending;
    logic [N_CH-1:0]  w_grant;
    logic [CH_W-1:0]  w_grant_idx;
    logic             w_grant_vld;
    logic [CYC_W-1:0] w_grant_cyc;

    assign w_pending   = ch_changed & ch_enable;
    assign w_grant_cyc = ch_cycles[w_grant_idx*CYC_W +: CYC_W];

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .i_req       (w_pending),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

`ifdef ENDSTOP_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_grant_oh     <= '0;
            ch_unlock      <= '0;
            evt.evt_valid  <= 1'b0;
            evt.evt_ch     <= '0;
            evt.evt_value  <= 1'b0;
            evt.evt_pos    <= '0;
            evt.evt_missed <= '0;
`ifdef ENDSTOP_TIMESTAMP_EN
            evt.evt_time   <= '0;
`endif
            for (int i = 0; i < N_CH; i++) begin
                r_last_cyc[i] <= '0;
            end
        end else begin
            ch_unlock <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        evt.evt_valid  <= 1'b1;
                        evt.evt_ch     <= w_grant_idx;
                        evt.evt_value  <= ch_value[w_grant_idx];
                        evt.evt_pos    <= ch_pos[w_grant_idx*POS_W +: POS_W];
                        // Mod-256 difference; one expected change per event.
                        evt.evt_missed <= w_grant_cyc - r_last_cyc[w_grant_idx] - CYC_W'(1);
`ifdef ENDSTOP_TIMESTAMP_EN
                        evt.evt_time   <= r_ts;
`endif
                        r_last_cyc[w_grant_idx] <= w_grant_cyc;
                        r_grant_oh     <= w_grant;
                        r_rr_ptr       <= (w_grant_idx == CH_W'(N_CH - 1)) ?
                                          '0 : w_grant_idx + CH_W'(1);
                        r_state        <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt.evt_ready) begin
                        evt.evt_valid <= 1'b0;
                        ch_unlock     <= r_grant_oh;
                        r_state       <= UNLOCK;
                    end
                end
                UNLOCK: begin
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_endstop_event_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_endstop_event_arbiter
// Description : Directed self-checking bench for endstop_event_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_endstop_event_arbiter;
    import endstop_pkg::*;

    localparam int N_CH  = 4;
    localparam int POS_W = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       ch_enable;
    logic [N_CH-1:0]       ch_changed;
    logic [N_CH-1:0]       ch_value;
    logic [N_CH*POS_W-1:0] ch_pos;
    logic [N_CH*CYC_W-1:0] ch_cycles;
    logic [N_CH-1:0]       ch_unlock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    endstop_event_arbiter_if #(.N_CH(N_CH), .POS_W(POS_W)) evt_if ();

    endstop_event_arbiter #(
        .N_CH  (N_CH),
        .POS_W (POS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_enable  (ch_enable),
        .ch_changed (ch_changed),
        .ch_value   (ch_value),
        .ch_pos     (ch_pos),
        .ch_cycles  (ch_cycles),
        .ch_unlock  (ch_unlock),
        .evt        (evt_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (evt_if.evt_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Handshake and emulate the channel dropping its latch on unlock.
    task automatic accept(output logic [N_CH-1:0] unl);
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        unl        = ch_unlock;
        ch_changed = ch_changed & ~ch_unlock;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ch_enable = '0; ch_changed = '0; ch_value = '0; ch_pos = '0; ch_cycles = '0;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_if.evt_valid); end
        total++; if (evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", evt_if.evt_ch); end
        total++; if (evt_if.evt_value !== 1'b0) begin bad++; $display("FAIL reset_value got=%b want=0", evt_if.evt_value); end
        total++; if (evt_if.evt_pos !== 64'd0) begin bad++; $display("FAIL reset_pos got=%h want=0", evt_if.evt_pos); end
        total++; if (evt_if.evt_missed !== 8'd0) begin bad++; $display("FAIL reset_missed got=%0d want=0", evt_if.evt_missed); end
        total++; if (ch_unlock !== 4'b0000) begin bad++; $display("FAIL reset_unlock got=%b want=0000", ch_unlock); end
`ifdef ENDSTOP_TIMESTAMP_EN
        total++; if (evt_if.evt_time !== 32'd0) begin bad++; $display("FAIL reset_time got=%0d want=0", evt_if.evt_time); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single();
        ch_enable = 4'hF;
        ch_value = 4'b0100;
        ch_pos[2*POS_W +: POS_W] = 64'h1234;
        ch_cycles[2*CYC_W +: CYC_W] = 8'd1;
        evt_if.evt_ready = 1'b1;
        ch_changed = 4'b0100;
        @(negedge clk);
        total++; if (evt_if.evt_valid !== 1'b1) begin bad++; $display("FAIL single_latency valid got=%b want=1", evt_if.evt_valid); end
        total++; if (evt_if.evt_ch !== 2'd2) begin bad++; $display("FAIL single_ch got=%0d want=2", evt_if.evt_ch); end
        total++; if (evt_if.evt_value !== 1'b1) begin bad++; $display("FAIL single_value got=%b want=1", evt_if.evt_value); end
        total++; if (evt_if.evt_pos !== 64'h1234) begin bad++; $display("FAIL single_pos got=%h want=1234", evt_if.evt_pos); end
        total++; if (evt_if.evt_missed !== 8'd0) begin bad++; $display("FAIL single_missed got=%0d want=0", evt_if.evt_missed); end
        total++; if (ch_unlock !== 4'b0000) begin bad++; $display("FAIL single_early_unlock got=%b want=0000", ch_unlock); end
        @(negedge clk);
        total++; if (ch_unlock !== 4'b0100) begin bad++; $display("FAIL single_unlock got=%b want=0100", ch_unlock); end
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b want=0", evt_if.evt_valid); end
        ch_changed = 4'b0000;
        @(negedge clk);
        total++; if (ch_unlock !== 4'b0000) begin bad++; $display("FAIL single_unlock_width got=%b want=0000", ch_unlock); end
        @(negedge clk);
        total++; if (ch_unlock !== 4'b0000 || evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL single_quiet unlock=%b valid=%b want 0000/0", ch_unlock, evt_if.evt_valid); end
    endtask

    task automatic test_contention();
        int              exp_ch  [4] = '{0, 1, 3, 0};
        logic [63:0]     exp_pos [4] = '{64'hA0, 64'hA1, 64'hA3, 64'hB0};
        logic            exp_val [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int              last_cyc;
        bit              got;
        logic [N_CH-1:0] unl;
        pulse_reset();
        ch_enable = 4'hF;
        ch_value  = 4'b1001;
        ch_pos[0*POS_W +: POS_W] = 64'hA0;
        ch_pos[1*POS_W +: POS_W] = 64'hA1;
        ch_pos[3*POS_W +: POS_W] = 64'hA3;
        ch_cycles = {8'd1, 8'd0, 8'd1, 8'd1};
        evt_if.evt_ready = 1'b1;
        ch_changed = 4'b1011;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(got);
            total++; if (!got) begin bad++; $display("FAIL contention_timeout grant=%0d got=none want=valid", k); end
            total++; if (int'(evt_if.evt_ch) != exp_ch[k]) begin bad++; $display("FAIL contention_order grant=%0d got=%0d want=%0d", k, evt_if.evt_ch, exp_ch[k]); end
            total++; if (evt_if.evt_pos !== exp_pos[k] || evt_if.evt_value !== exp_val[k] || evt_if.evt_missed !== 8'd0) begin
                bad++; $display("FAIL contention_data grant=%0d got pos=%h val=%b miss=%0d want pos=%h val=%b miss=0", k, evt_if.evt_pos, evt_if.evt_value, evt_if.evt_missed, exp_pos[k], exp_val[k]);
            end
            if (k == 1 || k == 2) begin
                total++; if (cyc - last_cyc != 4) begin bad++; $display("FAIL contention_spacing grant=%0d got=%0d want=4", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
            accept(unl);
            total++; if (unl !== (4'b0001 << exp_ch[k])) begin bad++; $display("FAIL contention_unlock grant=%0d got=%b want=%b", k, unl, 4'b0001 << exp_ch[k]); end
            if (k == 0) begin
                @(negedge clk);
                ch_pos[0*POS_W +: POS_W] = 64'hB0;
                ch_cycles[0*CYC_W +: CYC_W] = 8'd2;
                ch_changed[0] = 1'b1;
            end
        end
    endtask

    task automatic test_backpressure();
        bit              got;
        logic [N_CH-1:0] unl;
        pulse_reset();
        ch_enable = 4'hF;
        ch_value  = 4'b0010;
        ch_pos[1*POS_W +: POS_W] = 64'hABCD;
        ch_cycles = {8'd0, 8'd0, 8'd1, 8'd0};
        evt_if.evt_ready = 1'b0;
        ch_changed = 4'b0010;
        wait_valid(got);
        total++; if (!got || evt_if.evt_missed !== 8'd0) begin bad++; $display("FAIL bp_capture got valid=%b miss=%0d want 1/0", got, evt_if.evt_missed); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1 || evt_if.evt_pos !== 64'hABCD || evt_if.evt_value !== 1'b1 || ch_unlock !== 4'b0000) begin
                bad++; $display("FAIL bp_hold cycle=%0d got valid=%b ch=%0d pos=%h unlock=%b want 1/1/abcd/0000", k, evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_pos, ch_unlock);
            end
        end
        accept(unl);
        total++; if (unl !== 4'b0010) begin bad++; $display("FAIL bp_unlock got=%b want=0010", unl); end
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", evt_if.evt_valid); end
    endtask

    task automatic test_missed();
        logic [7:0]      cyc_tab [5] = '{8'd4, 8'd250, 8'd2, 8'd255, 8'd0};
        logic [7:0]      exp_mis [5] = '{8'd2, 8'd245, 8'd7, 8'd252, 8'd0};
        bit              got;
        logic [N_CH-1:0] unl;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ch_cycles[1*CYC_W +: CYC_W] = cyc_tab[k];
            ch_changed[1] = 1'b1;
            wait_valid(got);
            total++; if (!got || evt_if.evt_ch !== 2'd1) begin bad++; $display("FAIL missed_event step=%0d got valid=%b ch=%0d want 1/1", k, got, evt_if.evt_ch); end
            total++; if (evt_if.evt_missed !== exp_mis[k]) begin bad++; $display("FAIL missed_count step=%0d got=%0d want=%0d", k, evt_if.evt_missed, exp_mis[k]); end
            accept(unl);
        end
    endtask

    task automatic test_mask();
        bit              got;
        logic [N_CH-1:0] unl;
        pulse_reset();
        ch_enable = 4'b1110;
        ch_cycles = '0;
        ch_cycles[0*CYC_W +: CYC_W] = 8'd1;
        evt_if.evt_ready = 1'b1;
        ch_changed = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (evt_if.evt_valid !== 1'b0 || ch_unlock !== 4'b0000) begin bad++; $display("FAIL mask_block cycle=%0d got valid=%b unlock=%b want 0/0000", k, evt_if.evt_valid, ch_unlock); end
        end
        ch_enable = 4'b1111;
        wait_valid(got);
        total++; if (!got || evt_if.evt_ch !== 2'd0) begin bad++; $display("FAIL mask_release got valid=%b ch=%0d want 1/0", got, evt_if.evt_ch); end
        accept(unl);
        total++; if (unl !== 4'b0001) begin bad++; $display("FAIL mask_unlock got=%b want=0001", unl); end
    endtask

    task automatic test_reset_mid();
        bit got;
        @(negedge clk);
        evt_if.evt_ready = 1'b0;
        ch_changed = 4'b0100;
        wait_valid(got);
        total++; if (!got) begin bad++; $display("FAIL rstmid_capture got=none want=valid"); end
        reset = 1'b1;
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        total++; if (evt_if.evt_valid !== 1'b0 || ch_unlock !== 4'b0000) begin bad++; $display("FAIL rstmid_drop got valid=%b unlock=%b want 0/0000", evt_if.evt_valid, ch_unlock); end
        reset = 1'b0;
        ch_changed = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            total++; if (evt_if.evt_valid !== 1'b0 || ch_unlock !== 4'b0000) begin bad++; $display("FAIL rstmid_after got valid=%b unlock=%b want 0/0000", evt_if.evt_valid, ch_unlock); end
        end
    endtask

`ifdef ENDSTOP_TIMESTAMP_EN
    task automatic test_timestamp();
        bit              got;
        logic [31:0]     t1;
        logic [N_CH-1:0] unl;
        pulse_reset();
        ch_enable = 4'hF;
        evt_if.evt_ready = 1'b1;
        ch_changed = 4'b0001;
        wait_valid(got);
        t1 = evt_if.evt_time;
        accept(unl);
        repeat (98) @(negedge clk);
        ch_changed[1] = 1'b1;
        @(negedge clk);
        total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_time - t1 !== 32'd100) begin
            bad++; $display("FAIL timestamp_delta got valid=%b delta=%0d want 1/100", evt_if.evt_valid, evt_if.evt_time - t1);
        end
        accept(unl);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_missed();
        test_mask();
        test_reset_mid();
`ifdef ENDSTOP_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
